// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, mid-bit sampling, stop check.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer.
module uart_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS:0]   data_parity_out,
  output logic                 ready,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LBIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS:0]   shreg_q, shreg_d;
  logic [DATA_BITS:0]   dout_q, dout_d;
  logic                 ready_q, ready_d;
  logic                 fe_q, fe_d;
  logic                 rx_s;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
`else
  assign rx_s = rx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    fe_d    = fe_q;
    unique case (state_q)
      IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (cnt_q == HALF) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt_q == LAST) begin
            cnt_d          = '0;
            shreg_d[bit_q] = rx_s;
            if (bit_q == LBIT) begin
              bit_d   = '0;
              state_d = PARITY;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (cnt_q == LAST) begin
            cnt_d              = '0;
            shreg_d[DATA_BITS] = rx_s;
            state_d            = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            dout_d  = shreg_q;
            fe_d    = ~rx_s;
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Single-clk state, independent of the tick.
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_parity_out = dout_q;
  assign ready           = ready_q;
  assign frame_error     = fe_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: good frames, false start,
// framing error, mid-frame reset and back-to-back frames.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [8:0] data_parity_out;
  logic       ready;
  logic       frame_error;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic       tick_mode4 = 1'b0;
  logic [1:0] div = '0;

  logic [8:0] rise_q[$];
  logic       fe_q[$];
  logic [8:0] fall_q[$];
  logic       ready_prev = 1'b0;
  int         dbl_cnt = 0;

  uart_rx_ctrl #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_tick      (baud_tick),
    .rx             (rx),
    .data_parity_out(data_parity_out),
    .ready          (ready),
    .frame_error    (frame_error),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b1;
    forever begin
      @(negedge clk);
      if (tick_mode4) begin
        div       = div + 2'd1;
        baud_tick = (div == 2'd0);
      end else begin
        baud_tick = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (ready) begin
      rise_q.push_back(data_parity_out);
      fe_q.push_back(frame_error);
    end
    if (ready_prev && !ready) fall_q.push_back(data_parity_out);
    if (ready_prev && ready) dbl_cnt = dbl_cnt + 1;
    ready_prev = ready;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (baud_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic p,
                            input logic s);
    send_bit(1'b0);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag,
                              input logic [8:0] exp_d,
                              input logic exp_fe);
    check({tag, "_ready"}, 32'(rise_q.size() > 0), 32'd1);
    if (rise_q.size() > 0) begin
      check({tag, "_data"}, 32'(rise_q.pop_front()), 32'(exp_d));
      check({tag, "_fe"}, 32'(fe_q.pop_front()), 32'(exp_fe));
    end
    check({tag, "_fall"}, 32'(fall_q.size() > 0), 32'd1);
    if (fall_q.size() > 0)
      check({tag, "_fall_data"}, 32'(fall_q.pop_front()), 32'(exp_d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data_parity_out), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    wait_ticks(5);

    send_frame(8'h5A, 1'b0, 1'b1);
    wait_ticks(4);
    expect_frame("f5a", 9'h05A, 1'b0);
    check("f5a_pulses", 32'(rise_q.size()), 32'd0);
    check("f5a_idle", 32'(busy), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b1);
    wait_ticks(4);
    expect_frame("fa5", 9'h1A5, 1'b0);

    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("fs_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("fs_idle", 32'(busy), 32'd0);
    check("fs_no_ready", 32'(rise_q.size()), 32'd0);
    check("fs_hold_data", 32'(data_parity_out), 32'h1A5);

    send_frame(8'h3C, 1'b0, 1'b0);
    wait_ticks(20);
    expect_frame("f3c", 9'h03C, 1'b1);
    check("f3c_fe_hold", 32'(frame_error), 32'd1);
    check("f3c_idle", 32'(busy), 32'd0);

    send_frame(8'h81, 1'b0, 1'b1);
    wait_ticks(4);
    expect_frame("f81", 9'h081, 1'b0);
    check("f81_fe_hold", 32'(frame_error), 32'd0);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("mid_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_parity_out), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_fe", 32'(frame_error), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    wait_ticks(20);
    check("mid_no_ready", 32'(rise_q.size()), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_ticks(4);
    expect_frame("fff", 9'h0FF, 1'b0);

    tick_mode4 = 1'b1;
    wait_ticks(5);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    wait_ticks(4);
    check("b2b_count", 32'(rise_q.size()), 32'd2);
    expect_frame("b11", 9'h011, 1'b0);
    expect_frame("b22", 9'h022, 1'b0);
    check("b2b_idle", 32'(busy), 32'd0);
    check("ready_width", 32'(dbl_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART receiver.
- Detects the start bit on the serial line using a 16x oversample tick, samples each data bit and the parity bit at mid-bit, and checks the stop bit.
- Presents the assembled {parity, data} word to the parity checker and to the downstream consumer.
- Emits a one-cycle ready pulse; the checker latches the word on the falling edge of that pulse.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and >= 4.
- DATA_BITS, 8, data bits per frame, 5..8.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate
- rx  input  1  serial line, idle high
- data_parity_out  output  DATA_BITS+1  [DATA_BITS]=received parity bit, [DATA_BITS-1:0]=data, LSB received first
- ready  output  1  one-clk pulse, frame complete
- frame_error  output  1  stop bit sampled low on the last frame
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: rst low asynchronously forces IDLE, tick counter=0, bit counter=0, data_parity_out=0, ready=0, frame_error=0, busy=0. Reset mid-frame abandons the frame with no ready pulse.
- All state and counter updates occur only on clk rising edges where baud_tick=1, except the DONE->IDLE step and the ready drop.
- Tick counter: 0..OVERSAMPLE-1; cleared on every state entry.
- IDLE:
  - rx=0 on a tick -> START, tick counter=0.
- START:
  - When the counter reaches OVERSAMPLE/2-1 (mid start bit), re-sample rx.
  - rx=1 -> false start, return to IDLE with no other effect.
  - rx=0 -> DATA, counters=0.
- DATA:
  - Every OVERSAMPLE ticks, sample rx into bit position bit_cnt of an internal shift register.
  - After DATA_BITS samples -> PARITY.
- PARITY:
  - Sample rx after OVERSAMPLE ticks into the parity position -> STOP.
- STOP:
  - Sample rx after OVERSAMPLE ticks.
  - Copy the internal register to data_parity_out.
  - frame_error <= ~rx.
  - -> DONE.
- DONE:
  - Lasts exactly one clk (not tick-gated), with ready=1.
  - Next clk: ready=0, state=IDLE.
- data_parity_out:
  - Changes only on the STOP capture edge.
  - Is stable for the whole ready pulse and its falling edge.
  - Holds until the next frame's STOP capture.
- frame_error:
  - Updated only at STOP capture; holds until then.
- ready:
  - Latency is one clk after the STOP sample edge.
  - ready is never high for two consecutive clks.
- A falling rx edge during DONE is ignored; it is detected on the next tick in IDLE if rx is still low.
- The controller never checks parity itself; the parity bit is passed through in data_parity_out.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined:
  - rx passes through a 2-flop synchronizer clocked by clk before any use.
  - Both flops reset to 1.
  - All sample points shift 2 clks later.
- Undefined:
  - rx is used directly, for a synchronous source.
  - No added latency.

Test Plan:
- baud_tick tied 1, OVERSAMPLE=16, frame 0 | 0x5A LSB-first | parity 0 | stop 1 (16 clks/bit):
  - ready pulses exactly once, 1 clk wide.
  - data_parity_out=9'h05A; frame_error=0.
  - busy high from start detect to DONE.
- Same frame with parity 1 and data 0xA5 -> data_parity_out=9'h1A5.
- rx low for 4 clks then high, tick=1 -> START rejects the start bit and returns to IDLE.
  - No ready; busy falls back to 0 within 8 clks.
- Frame 0x3C with stop bit driven 0:
  - ready pulses; frame_error=1.
  - Next good frame 0x81 clears frame_error=0 and gives data_parity_out=9'h081 (parity 0).
- rst pulled low in the middle of DATA after 3 bits:
  - All outputs return to 0 immediately.
  - After release, a full frame 0xFF with parity 0 is received correctly as 9'h0FF.
- baud_tick every 4th clk, back-to-back frames 0x11 then 0x22 with no idle gap:
  - Two ready pulses.
  - data_parity_out=9'h011, then 9'h022 (parity 0 both).
  - data_parity_out is stable at each ready falling edge.
